// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch-unit bus bundling memory handshake, control inputs and PC/instruction outputs
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  OP;
  logic [5:0]  func;
  logic        instr_valid;
  logic        exec_done;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_count;
  modport master (
    output imem_req, imem_addr, instr, OP, func, instr_valid, pc, pc_plus4, retired_count,
    input  imem_ready, imem_rdata, exec_done, Branch, Jump, Zero
  );
  modport slave (
    input  imem_req, imem_addr, instr, OP, func, instr_valid, pc, pc_plus4, retired_count,
    output imem_ready, imem_rdata, exec_done, Branch, Jump, Zero
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder and one-at-a-time instruction fetcher for the single-cycle MIPS core
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, cnt_q, cnt_d, next_pc, pc_plus4, br_off;
  logic fetch_ok, retire;
  // state and datapath registers, reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state and next-PC selection; Jump has priority over a taken branch
  always_comb begin
    fetch_ok = (state_q == FETCH) && bus.imem_ready;
    retire   = (state_q == ISSUE) && bus.exec_done;
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    next_pc  = bus.Jump ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
               (bus.Branch && bus.Zero) ? pc_plus4 + br_off : pc_plus4;
    state_d  = (state_q == IDLE) ? FETCH :
               (state_q == FETCH) ? (bus.imem_ready ? ISSUE : FETCH) :
               (bus.exec_done ? FETCH : ISSUE);
    instr_d  = fetch_ok ? bus.imem_rdata : instr_q;
    pc_d     = retire ? next_pc : pc_q;
    cnt_d    = cnt_q + {31'd0, retire};
  end
  // outputs decoded from the registered state and instruction
  always_comb begin
    bus.imem_req      = (state_q == FETCH);
    bus.instr_valid   = (state_q == ISSUE);
    bus.imem_addr     = pc_q;
    bus.pc            = pc_q;
    bus.pc_plus4      = pc_plus4;
    bus.instr         = instr_q;
    bus.OP            = instr_q[31:26];
    bus.func          = instr_q[5:0];
    bus.retired_count = cnt_q;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random stimulus against a transaction-level fetch model
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic clk = 0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_pc, m_instr, m_cnt;
  logic m_idle, m_have;
  instr_fetch_unit_if bus();
  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] target(input logic [31:0] pc, input logic [31:0] ins, input logic b, input logic j, input logic z);
    logic [31:0] p4;
    logic signed [31:0] off;
    p4 = pc + 32'd4;
    off = $signed(ins[15:0]);
    if (j) return (p4 & 32'hF000_0000) + ({6'd0, ins[25:0]} * 32'd4);
    if (b && z) return p4 + off * 4;
    return p4;
  endfunction
  task automatic step(input logic r, input logic rdy, input logic [31:0] rd, input logic d, input logic b, input logic j, input logic z);
    reset = r;
    bus.imem_ready = rdy;
    bus.imem_rdata = rd;
    bus.exec_done = d;
    bus.Branch = b;
    bus.Jump = j;
    bus.Zero = z;
    if (r) begin
      m_pc = RST_PC; m_instr = 0; m_cnt = 0; m_idle = 1; m_have = 0;
    end else if (m_idle) m_idle = 0;
    else if (!m_have) begin
      if (rdy) begin m_instr = rd; m_have = 1; end
    end else if (d) begin
      m_pc = target(m_pc, m_instr, b, j, z);
      m_cnt++;
      m_have = 0;
    end
    @(posedge clk);
    #1;
    chk("imem_req", {31'd0, bus.imem_req}, {31'd0, !m_idle && !m_have});
    chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_have});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("instr", bus.instr, m_instr);
    chk("OP", {26'd0, bus.OP}, {26'd0, m_instr[31:26]});
    chk("func", {26'd0, bus.func}, {26'd0, m_instr[5:0]});
    chk("retired", bus.retired_count, m_cnt);
  endtask
  task automatic run_instr(input logic [31:0] rd, input logic b, input logic j, input logic z, input int wr, input int wd);
    for (int i = 0; i < wr; i++) step(0, 0, $urandom, 1'($urandom_range(0, 1)), 0, 0, 0);
    step(0, 1, rd, 0, 0, 0, 0);
    for (int i = 0; i < wd; i++) step(0, 1'($urandom_range(0, 1)), $urandom, 0, 1, 1, 1);
    step(0, 0, $urandom, 1, b, j, z);
  endtask
  initial begin
    reset = 1;
    bus.imem_ready = 0; bus.imem_rdata = 0; bus.exec_done = 0;
    bus.Branch = 0; bus.Jump = 0; bus.Zero = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    step(0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    chk("req_first", {31'd0, bus.imem_req}, 32'd1);
    chk("addr_first", bus.imem_addr, 32'h0);
    run_instr({6'h04, 10'd0, 16'hFFFE}, 1, 0, 1, 0, 0);
    chk("br_wrap_back", bus.imem_addr, 32'hFFFF_FFFC);
    run_instr(32'h0123_4567, 0, 0, 0, 3, 2);
    chk("pc_wrap", bus.imem_addr, 32'h0);
    chk("wrap_count", bus.retired_count, 32'd2);
    run_instr({6'h02, 26'h4}, 0, 1, 0, 0, 0);
    chk("jump_0x10", bus.imem_addr, 32'h10);
    run_instr({6'h04, 10'd0, 16'hFFFC}, 1, 0, 1, 0, 1);
    chk("br_taken", bus.imem_addr, 32'h4);
    run_instr({6'h02, 26'h4}, 0, 1, 0, 1, 0);
    run_instr({6'h04, 10'd0, 16'hFFFC}, 1, 0, 0, 0, 0);
    chk("br_not_taken", bus.imem_addr, 32'h14);
    run_instr({6'h02, 26'h3FF_FFFF}, 0, 1, 0, 0, 0);
    chk("jump_far", bus.imem_addr, 32'h0FFF_FFFC);
    run_instr({6'h02, 26'h8}, 0, 1, 0, 0, 0);
    chk("jump_region", bus.imem_addr, 32'h1000_0020);
    run_instr({6'h04, 26'h40}, 1, 1, 1, 0, 0);
    chk("jump_over_br", bus.imem_addr, 32'h1000_0100);
    step(0, 0, $urandom, 1, 0, 0, 0);
    step(1, 1, 32'hCAFE_F00D, 1, 0, 0, 0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.pc, RST_PC);
    chk("rst_count", bus.retired_count, 32'h0);
    step(0, 1, $urandom, 1, 0, 0, 0);
    step(0, 0, $urandom, 1, 0, 0, 0);
    chk("stray_done", bus.retired_count, 32'h0);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
